ysyx_23060236_mdu: RTL

- Iterative RV32M multiply/divide unit. It is the parametrised successor of the single-cycle execute ALU.
- Sits beside the execute stage. Execute hands it M-extension ops (opcode OP, funct7=0000001) through a valid/ready handshake.
- Result returns with the destination register on an output valid/ready channel that feeds the write-back path.
- Computes one quotient bit or one partial-product bit per cycle, for any XLEN. Supports pipeline flush.

---
 rtl/ysyx_23060236_mdu.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060236_mdu.sv
// Iterative RV32M multiply/divide unit: one partial-product or quotient bit per cycle.
// Valid/ready on both sides; flush kills the op in flight.
module ysyx_23060236_mdu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RD_W  = 4,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [RD_W-1:0] rd,
  input  logic            reg_wen,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_val,
  output logic [RD_W-1:0] out_rd,
  output logic            out_reg_wen
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e              state_q;
  logic [1:0]          op_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                sign_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [2*XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]     mplier_q;
  logic [XLEN-1:0]     rem_q;
  logic [XLEN-1:0]     quot_q;
  logic [XLEN-1:0]     divisor_q;
  logic                out_valid_q;
  logic [XLEN-1:0]     out_val_q;
  logic [RD_W-1:0]     out_rd_q;
  logic                out_reg_wen_q;

  // Accept-side decode
  logic            s1_neg, s2_neg, sign_in, div_zero, div_ovf, special;
  logic [XLEN-1:0] s1_mag, s2_mag, special_val;

  always_comb begin
    s1_neg   = src1[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                               (funct3[2] & ~funct3[0]));
    s2_neg   = src2[XLEN-1] & ((funct3 == 3'b001) | (funct3[2] & ~funct3[0]));
    s1_mag   = s1_neg ? -src1 : src1;
    s2_mag   = s2_neg ? -src2 : src2;
    // Remainder takes the dividend's sign; everything else the product of signs
    sign_in  = (funct3[2] & funct3[1]) ? s1_neg : (s1_neg ^ s2_neg);
    div_zero = (src2 == '0);
    div_ovf  = funct3[2] & ~funct3[0] & (src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&src2);
    special  = funct3[2] & (div_zero | div_ovf);
    if (div_zero) special_val = funct3[1] ? src1 : '1;
    else          special_val = funct3[1] ? '0 : src1;
  end

  // Iteration datapath
  logic [2*XLEN-1:0] mul_acc_nx, mul_res;
  logic [XLEN:0]     div_wide;
  logic              div_ge;
  logic [XLEN-1:0]   rem_nx, quot_nx, rem_fix, quot_fix, mul_sel, div_sel;

  always_comb begin
    mul_acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_res    = sign_q ? -mul_acc_nx : mul_acc_nx;
    mul_sel    = (op_q == 2'b00) ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN];
    div_wide   = {rem_q, quot_q[XLEN-1]};
    div_ge     = div_wide >= {1'b0, divisor_q};
    // When div_ge holds the difference is below the divisor, so XLEN bits suffice
    rem_nx     = div_ge ? (div_wide[XLEN-1:0] - divisor_q) : div_wide[XLEN-1:0];
    quot_nx    = {quot_q[XLEN-2:0], div_ge};
    rem_fix    = sign_q ? -rem_nx : rem_nx;
    quot_fix   = sign_q ? -quot_nx : quot_nx;
    div_sel    = op_q[1] ? rem_fix : quot_fix;
  end

  assign in_ready    = (state_q == StIdle) & ~flush;
  assign out_valid   = out_valid_q;
  assign out_val     = out_val_q;
  assign out_rd      = out_rd_q;
  assign out_reg_wen = out_reg_wen_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      op_q          <= '0;
      cnt_q         <= '0;
      sign_q        <= 1'b0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      divisor_q     <= '0;
      out_valid_q   <= 1'b0;
      out_val_q     <= '0;
      out_rd_q      <= '0;
      out_reg_wen_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            op_q          <= funct3[1:0];
            sign_q        <= sign_in;
            out_rd_q      <= rd;
            out_reg_wen_q <= reg_wen;
            cnt_q         <= CNT_W'(XLEN);
            if (special) begin
              out_val_q   <= special_val;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else if (funct3[2]) begin
              rem_q     <= '0;
              quot_q    <= s1_mag;
              divisor_q <= s2_mag;
              state_q   <= StDiv;
            end else begin
              acc_q    <= '0;
              mcand_q  <= {{XLEN{1'b0}}, s1_mag};
              mplier_q <= s2_mag;
              state_q  <= StMul;
            end
          end
        end
        StMul: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            acc_q    <= mul_acc_nx;
            mplier_q <= mplier_q >> 1;
            mcand_q  <= mcand_q << 1;
            cnt_q    <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              out_val_q   <= mul_sel;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StDiv: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            rem_q  <= rem_nx;
            quot_q <= quot_nx;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              out_val_q   <= div_sel;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StDone: begin
          if (flush || out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
